uart_reg_responder: RTL and testbench

// Command-level responder on the far end of the UART link: consumes received bytes, decodes

---
 rtl/uart_reg_responder_if.sv | 32 +++
 rtl/uart_reg_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_reg_responder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_responder_if.sv
// Byte-level bus between the UART receiver/transmitter and the register responder,
// plus the register write port toward the system.
//   rx_byte/rx_valid     received byte and its one-cycle strobe
//   tx_dv                transmitter idle (1 = ready to accept tx_start)
//   tx_start/tx_in       one-cycle launch strobe and the byte to send
//   reg_wr_en/addr/data  one-cycle register write mirror
//   busy                 responder is inside a frame or a reply
// slave  : the responder side
// master : the UART / system side (a testbench takes this role)
interface uart_reg_responder_if #(
   parameter int ADDR_WIDTH = 4
);
   logic [7:0]            rx_byte;
   logic                  rx_valid;
   logic                  tx_dv;
   logic                  tx_start;
   logic [7:0]            tx_in;
   logic                  reg_wr_en;
   logic [ADDR_WIDTH-1:0] reg_wr_addr;
   logic [7:0]            reg_wr_data;
   logic                  busy;

   modport slave (
      input  rx_byte, rx_valid, tx_dv,
      output tx_start, tx_in, reg_wr_en, reg_wr_addr, reg_wr_data, busy
   );

   modport master (
      output rx_byte, rx_valid, tx_dv,
      input  tx_start, tx_in, reg_wr_en, reg_wr_addr, reg_wr_data, busy
   );
endinterface

// File: rtl/uart_reg_responder.sv
// Command responder on the far end of the UART link. Decodes WRITE (0x57,addr,data)
// and READ (0x52,addr) frames, owns a 2**ADDR_WIDTH x 8 register file, mirrors every
// write on a one-cycle write port and answers each frame through the byte transmitter
// (ACK 0x06 for writes, register contents for reads, NAK 0x15 for errors).
// Ports:
//   clk_i    system clock
//   rst_n_i  synchronous reset, active low
//   bus      uart_reg_responder_if.slave (rx byte in, tx byte out, register write port, busy)
// Optional feature macro UART_RESP_CHKSUM_EN: frames carry a trailing XOR checksum byte
// and every reply is sent as the pair b, ~b.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for a command byte
// S_GET_ADDR  | command accepted, waiting for the address byte
// S_GET_DATA  | write only, waiting for the data byte
// S_GET_CSUM  | checksum build only, waiting for the checksum byte
// S_EXEC      | single cycle: perform write / fetch read data, pick reply byte
// S_SEND      | reply byte valid, launch it as soon as the transmitter is idle
// S_WAIT_BUSY | byte launched, waiting for the transmitter to go busy
// S_WAIT_DONE | waiting for the transmitter to return to idle
module uart_reg_responder #(
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   uart_reg_responder_if.slave   bus
);

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK    = 8'h06;
   localparam logic [7:0] NAK    = 8'h15;
   localparam int         DEPTH  = 2 ** ADDR_WIDTH;
   localparam int         CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_DATA,
      S_EXEC,
      S_SEND,
      S_WAIT_BUSY,
      S_WAIT_DONE
`ifdef UART_RESP_CHKSUM_EN
      , S_GET_CSUM
`endif
   } state_t;

   state_t           state_q, state_d;
   logic             is_wr_q, is_wr_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       tx_in_q, tx_in_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef UART_RESP_CHKSUM_EN
   logic [7:0]       csum_q, csum_d;
   logic             second_q, second_d;
`endif

   logic [7:0] regs_q [DEPTH];

   logic       tx_start;
   logic       wr_en;
   logic       addr_ok;
   logic       frame_ok;
   logic       in_frame;
   logic [7:0] rd_data;

   // Full 8-bit address byte is kept so out-of-range addresses can be rejected.
   assign addr_ok = ({24'd0, addr_q} < (32'd1 << ADDR_WIDTH));
   assign rd_data = regs_q[addr_q[ADDR_WIDTH-1:0]];

`ifdef UART_RESP_CHKSUM_EN
   // The checksum byte is folded into the running XOR, so a good frame leaves zero.
   assign frame_ok = addr_ok && (csum_q == 8'h00);
   assign in_frame = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA) ||
                     (state_q == S_GET_CSUM);
`else
   assign frame_ok = addr_ok;
   assign in_frame = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         is_wr_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         tx_in_q  <= '0;
         cnt_q    <= '0;
`ifdef UART_RESP_CHKSUM_EN
         csum_q   <= '0;
         second_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         is_wr_q  <= is_wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         tx_in_q  <= tx_in_d;
         cnt_q    <= cnt_d;
`ifdef UART_RESP_CHKSUM_EN
         csum_q   <= csum_d;
         second_q <= second_d;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (wr_en) begin
         regs_q[addr_q[ADDR_WIDTH-1:0]] <= data_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      is_wr_d  = is_wr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      tx_in_d  = tx_in_q;
      cnt_d    = cnt_q;
`ifdef UART_RESP_CHKSUM_EN
      csum_d   = csum_q;
      second_d = second_q;
`endif
      tx_start = 1'b0;
      wr_en    = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.rx_valid) begin
`ifdef UART_RESP_CHKSUM_EN
               csum_d   = bus.rx_byte;
               second_d = 1'b0;
`endif
               if (bus.rx_byte == CMD_WR) begin
                  is_wr_d = 1'b1;
                  state_d = S_GET_ADDR;
               end else if (bus.rx_byte == CMD_RD) begin
                  is_wr_d = 1'b0;
                  state_d = S_GET_ADDR;
               end else begin
                  tx_in_d = NAK;
                  state_d = S_SEND;
               end
            end
         end
         S_GET_ADDR: begin
            if (bus.rx_valid) begin
               addr_d = bus.rx_byte;
               cnt_d  = '0;
`ifdef UART_RESP_CHKSUM_EN
               csum_d  = csum_q ^ bus.rx_byte;
               state_d = is_wr_q ? S_GET_DATA : S_GET_CSUM;
`else
               state_d = is_wr_q ? S_GET_DATA : S_EXEC;
`endif
            end
         end
         S_GET_DATA: begin
            if (bus.rx_valid) begin
               data_d = bus.rx_byte;
               cnt_d  = '0;
`ifdef UART_RESP_CHKSUM_EN
               csum_d  = csum_q ^ bus.rx_byte;
               state_d = S_GET_CSUM;
`else
               state_d = S_EXEC;
`endif
            end
         end
`ifdef UART_RESP_CHKSUM_EN
         S_GET_CSUM: begin
            if (bus.rx_valid) begin
               csum_d  = csum_q ^ bus.rx_byte;
               cnt_d   = '0;
               state_d = S_EXEC;
            end
         end
`endif
         S_EXEC: begin
            state_d = S_SEND;
            if (!frame_ok) begin
               tx_in_d = NAK;
            end else if (is_wr_q) begin
               wr_en   = 1'b1;
               tx_in_d = ACK;
            end else begin
               tx_in_d = rd_data;
            end
         end
         S_SEND: begin
            if (bus.tx_dv) begin
               tx_start = 1'b1;
               state_d  = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (!bus.tx_dv) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (bus.tx_dv) begin
`ifdef UART_RESP_CHKSUM_EN
               if (!second_q) begin
                  second_d = 1'b1;
                  tx_in_d  = ~tx_in_q;
                  state_d  = S_SEND;
               end else begin
                  state_d = S_IDLE;
               end
`else
               state_d = S_IDLE;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Inter-byte timeout while collecting a frame: abandon silently.
      if (in_frame && !bus.rx_valid) begin
         if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign bus.tx_start    = tx_start;
   assign bus.tx_in       = tx_in_q;
   assign bus.reg_wr_en   = wr_en;
   assign bus.reg_wr_addr = wr_en ? addr_q[ADDR_WIDTH-1:0] : '0;
   assign bus.reg_wr_data = wr_en ? data_q : 8'h00;
   assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_responder.sv
module tb_uart_reg_responder;

   localparam int AW      = 4;
   localparam int TIMEOUT = 64;
   localparam int TXLEN   = 6;
`ifdef UART_RESP_CHKSUM_EN
   localparam int REPLY_N = 2;
`else
   localparam int REPLY_N = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic tx_busy = 1'b0;
   logic tx_hold = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_start = 0;
   int   n_wr    = 0;
   int   first_start_cyc = -1;
   int   last_rx_cyc = 0;
   bit   overlap = 0;
   logic [AW-1:0] wr_addr_seen;
   logic [7:0]    wr_data_seen;
   logic [7:0]    rxq[$];

   uart_reg_responder_if #(.ADDR_WIDTH(AW)) bus ();

   uart_reg_responder #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus.tx_dv = !tx_busy && !tx_hold;

   always @(negedge clk) begin
      if (bus.tx_start) begin
         rxq.push_back(bus.tx_in);
         n_start++;
         if (first_start_cyc < 0) first_start_cyc = cyc;
      end
      if (bus.reg_wr_en) begin
         n_wr++;
         wr_addr_seen = bus.reg_wr_addr;
         wr_data_seen = bus.reg_wr_data;
      end
      if (bus.tx_start && bus.reg_wr_en) overlap = 1;
   end

   // Transmitter model: goes busy the cycle after a launch, idle again TXLEN cycles later.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_start) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (TXLEN) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   function automatic logic [15:0] exp_reply(input logic [7:0] b);
`ifdef UART_RESP_CHKSUM_EN
      return {b, ~b};
`else
      return {8'h00, b};
`endif
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 bus.rx_byte = b;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      last_rx_cyc = cyc;
   endtask

   task automatic send_wr(input logic [7:0] a, input logic [7:0] d);
      send_byte(8'h57);
      send_byte(a);
      send_byte(d);
`ifdef UART_RESP_CHKSUM_EN
      send_byte(8'h57 ^ a ^ d);
`endif
   endtask

   task automatic send_rd(input logic [7:0] a);
      send_byte(8'h52);
      send_byte(a);
`ifdef UART_RESP_CHKSUM_EN
      send_byte(8'h52 ^ a);
`endif
   endtask

   task automatic get_reply(output logic [15:0] r, output bit to);
      r  = 16'h0000;
      to = 0;
      for (int i = 0; i < 3000 && (rxq.size() < REPLY_N || bus.busy); i++) @(negedge clk);
      if (rxq.size() < REPLY_N || bus.busy) to = 1;
      while (rxq.size() > 0) r = {r[7:0], rxq.pop_front()};
   endtask

   task automatic test_reset;
      logic [15:0] r;
      bit to;
      rst_n = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_byte = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
      n_tests++;
      if (bus.reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.reg_wr_en); end
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_tests++;
      if (bus.tx_in !== 8'h00) begin n_fail++; $display("FAIL reset_tx_in: got %h expected 00", bus.tx_in); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_rd(8'h03);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h00)) begin n_fail++; $display("FAIL reset_read3: got %h expected %h timeout %0d", r, exp_reply(8'h00), to); end
   endtask

   task automatic test_write;
      logic [15:0] r;
      bit to;
      int wr0;
      wr0 = n_wr;
      first_start_cyc = -1;
      send_wr(8'h03, 8'hA5);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h06)) begin n_fail++; $display("FAIL write_ack: got %h expected %h timeout %0d", r, exp_reply(8'h06), to); end
      n_tests++;
      if (n_wr - wr0 !== 1) begin n_fail++; $display("FAIL write_pulses: got %0d expected 1", n_wr - wr0); end
      n_tests++;
      if (wr_addr_seen !== 4'h3 || wr_data_seen !== 8'hA5) begin n_fail++; $display("FAIL write_port: got %h/%h expected 3/a5", wr_addr_seen, wr_data_seen); end
      n_tests++;
      if (first_start_cyc - last_rx_cyc !== 1) begin n_fail++; $display("FAIL write_latency: got %0d expected 1", first_start_cyc - last_rx_cyc); end
      send_rd(8'h03);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'hA5)) begin n_fail++; $display("FAIL read3: got %h expected %h", r, exp_reply(8'hA5)); end
      send_wr(8'h0F, 8'h5A);
      get_reply(r, to);
      send_rd(8'h0F);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h5A)) begin n_fail++; $display("FAIL read_top_addr: got %h expected %h", r, exp_reply(8'h5A)); end
   endtask

   task automatic test_errors;
      logic [15:0] r;
      bit to;
      int wr0;
      send_byte(8'h41);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h15)) begin n_fail++; $display("FAIL unknown_cmd: got %h expected %h", r, exp_reply(8'h15)); end
      wr0 = n_wr;
      send_wr(8'h10, 8'h77);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h15)) begin n_fail++; $display("FAIL bad_addr_wr: got %h expected %h", r, exp_reply(8'h15)); end
      n_tests++;
      if (n_wr !== wr0) begin n_fail++; $display("FAIL bad_addr_no_write: got %0d expected %0d", n_wr, wr0); end
      send_rd(8'hFF);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h15)) begin n_fail++; $display("FAIL bad_addr_rd: got %h expected %h", r, exp_reply(8'h15)); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] r;
      bit to;
      send_wr(8'h07, 8'h11);
      get_reply(r, to);
      send_rd(8'h07);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h11)) begin n_fail++; $display("FAIL raw_read: got %h expected %h", r, exp_reply(8'h11)); end
      send_wr(8'h07, 8'hC3);
      get_reply(r, to);
      send_rd(8'h07);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'hC3)) begin n_fail++; $display("FAIL raw_read2: got %h expected %h", r, exp_reply(8'hC3)); end
   endtask

   task automatic test_timeout;
      logic [15:0] r;
      bit to;
      int s0, w0;
      send_wr(8'h02, 8'h33);
      get_reply(r, to);
      s0 = n_start;
      w0 = n_wr;
      send_byte(8'h57);
      send_byte(8'h02);
      repeat (60) @(negedge clk);
      n_tests++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got busy %b expected 1", bus.busy); end
      for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_drop: got busy %b expected 0", bus.busy); end
      n_tests++;
      if (n_start !== s0 || n_wr !== w0) begin n_fail++; $display("FAIL timeout_silent: got starts %0d writes %0d expected %0d %0d", n_start, n_wr, s0, w0); end
      send_rd(8'h02);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h33)) begin n_fail++; $display("FAIL timeout_old_value: got %h expected %h", r, exp_reply(8'h33)); end
   endtask

   task automatic test_backpressure;
      logic [15:0] r;
      bit to;
      int s0;
      s0 = n_start;
      tx_hold = 1'b1;
      send_rd(8'h03);
      repeat (2) @(negedge clk);
      n_tests++;
      if (bus.tx_in !== 8'hA5) begin n_fail++; $display("FAIL bp_tx_in_early: got %h expected a5", bus.tx_in); end
      send_byte(8'h41);
      repeat (100) @(negedge clk);
      n_tests++;
      if (n_start !== s0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_wait: got starts %0d busy %b expected %0d 1", n_start, bus.busy, s0); end
      n_tests++;
      if (bus.tx_in !== 8'hA5) begin n_fail++; $display("FAIL bp_tx_in_stable: got %h expected a5", bus.tx_in); end
      @(posedge clk);
      #1 tx_hold = 1'b0;
      get_reply(r, to);
      repeat (10) @(negedge clk);
      n_tests++;
      if (to || r !== exp_reply(8'hA5)) begin n_fail++; $display("FAIL bp_reply: got %h expected %h", r, exp_reply(8'hA5)); end
      n_tests++;
      if (n_start - s0 !== REPLY_N) begin n_fail++; $display("FAIL bp_start_count: got %0d expected %0d", n_start - s0, REPLY_N); end
   endtask

`ifdef UART_RESP_CHKSUM_EN
   task automatic test_chksum;
      logic [15:0] r;
      bit to;
      int w0;
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h3C); send_byte(8'h6A);
      get_reply(r, to);
      n_tests++;
      if (to || r !== 16'h06F9) begin n_fail++; $display("FAIL csum_good: got %h expected 06f9", r); end
      w0 = n_wr;
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h99); send_byte(8'h00);
      get_reply(r, to);
      n_tests++;
      if (to || r !== 16'h15EA) begin n_fail++; $display("FAIL csum_bad: got %h expected 15ea", r); end
      n_tests++;
      if (n_wr !== w0) begin n_fail++; $display("FAIL csum_bad_no_write: got %0d expected %0d", n_wr, w0); end
      send_rd(8'h01);
      get_reply(r, to);
      n_tests++;
      if (to || r !== 16'h3CC3) begin n_fail++; $display("FAIL csum_read: got %h expected 3cc3", r); end
   endtask
`endif

   task automatic test_mid_reset;
      logic [15:0] r;
      bit to;
      int w0;
      w0 = n_wr;
      send_byte(8'h57);
      send_byte(8'h03);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.busy !== 1'b0 || bus.tx_in !== 8'h00) begin n_fail++; $display("FAIL midreset_idle: got busy %b tx_in %h expected 0 00", bus.busy, bus.tx_in); end
      send_rd(8'h03);
      get_reply(r, to);
      n_tests++;
      if (to || r !== exp_reply(8'h00)) begin n_fail++; $display("FAIL midreset_cleared: got %h expected %h", r, exp_reply(8'h00)); end
      n_tests++;
      if (n_wr !== w0) begin n_fail++; $display("FAIL midreset_no_write: got %0d expected %0d", n_wr, w0); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_errors();
      test_back_to_back();
      test_timeout();
      test_backpressure();
`ifdef UART_RESP_CHKSUM_EN
      test_chksum();
`endif
      test_mid_reset();
      n_tests++;
      if (overlap) begin n_fail++; $display("FAIL wr_tx_overlap: got 1 expected 0"); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
